// File: rtl/wbconsole_gen_pkg.sv
`default_nettype none
// wbconsole_gen_pkg -- register map and status bit positions of the console port.  Rev 1.0
package wbconsole_gen_pkg;

   typedef enum logic [1:0] {
      REG_SETUP = 2'd0,
      REG_FIFO  = 2'd1,
      REG_RXREG = 2'd2,
      REG_TXREG = 2'd3
   } reg_addr_t;

   localparam int BIT_RX_EMPTY  = 8;
   localparam int BIT_TIMEOUT   = 9;
   localparam int BIT_TX_NEMPTY = 8;
   localparam int BIT_TX_FULL   = 9;
   localparam int BIT_ERR       = 12;
   localparam int BIT_TXHALF    = 13;
   localparam int BIT_RESET     = 12;

endpackage
`default_nettype wire

// File: rtl/wbconsole_gen_sfifo_fwft.sv
`default_nettype none
// sfifo_fwft -- first-word-fall-through FIFO with fill count, sync clear and
// same-cycle push/pop (a push into a full FIFO is accepted when a pop frees a slot).  Rev 1.0
module sfifo_fwft #(
   parameter int WIDTH  = 8,
   parameter int LGFLEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [WIDTH-1:0]  push_data,
   input  logic              pop,
   output logic [WIDTH-1:0]  head,
   output logic [LGFLEN:0]   fill,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   localparam logic [LGFLEN:0] DEPTH = {1'b1, {LGFLEN{1'b0}}};

   logic [WIDTH-1:0]  mem [0:(1<<LGFLEN)-1];
   logic [LGFLEN-1:0] wr_ptr;
   logic [LGFLEN-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty    = (fill == '0);
   assign full     = (fill == DEPTH);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign overflow = push && !do_push && !clr;
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + LGFLEN'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + LGFLEN'(1);
         case ({do_push, do_pop})
            2'b10:   fill <= fill + (LGFLEN+1)'(1);
            2'b01:   fill <= fill - (LGFLEN+1)'(1);
            default: fill <= fill;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !clr)
         mem[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/wbconsole_gen.sv
`default_nettype none
// wbconsole_gen -- two-cycle pipelined Wishbone console port with RX/TX FIFOs,
// programmable RX fill threshold and RX idle-timeout interrupt.  Rev 1.0
module wbconsole_gen
   import wbconsole_gen_pkg::*;
#(
   parameter int BW     = 8,
   parameter int LGFLEN = 4,
   parameter int TOW    = 16
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_wb_cyc,
   input  logic           i_wb_stb,
   input  logic           i_wb_we,
   input  logic [1:0]     i_wb_addr,
   input  logic [31:0]    i_wb_data,
   output logic           o_wb_ack,
   output logic           o_wb_stall,
   output logic [31:0]    o_wb_data,
   output logic           o_console_stb,
   output logic [BW-1:0]  o_console_data,
   input  logic           i_console_busy,
   input  logic           i_console_stb,
   input  logic [BW-1:0]  i_console_data,
   output logic           o_rx_int,
   output logic           o_rxthresh_int,
   output logic           o_tx_int,
   output logic           o_txfifo_int
);

   localparam logic [LGFLEN:0] DEPTH = {1'b1, {LGFLEN{1'b0}}};
   localparam logic [LGFLEN:0] HALF  = {2'b01, {(LGFLEN-1){1'b0}}};

   logic            req;
   logic            we;
   reg_addr_t       addr;
   logic [31:0]     wdata;
   logic            ack;
   logic [31:0]     rd_word;

   logic [10:0]     rx_thresh;
   logic [TOW-1:0]  timeout;
   logic [TOW-1:0]  to_count;
   logic [TOW-1:0]  to_inc;
   logic            to_flag;
   logic            to_clear;
   logic            rx_err;
   logic            tx_err;

   logic            wr_req;
   logic            rd_req;
   logic            setup_wr;
   logic            rxreg_rd;
   logic            rx_clr;
   logic            tx_clr;
   logic            tx_push;
   logic            tx_pop;

   logic [BW-1:0]   rx_head;
   logic [BW-1:0]   tx_head;
   logic [LGFLEN:0] rx_fill;
   logic [LGFLEN:0] tx_fill;
   logic [LGFLEN:0] tx_free;
   logic            rx_full;
   logic            rx_empty;
   logic            tx_full;
   logic            tx_empty;
   logic            rx_ovf;
   logic            tx_ovf;
   logic [10:0]     thresh_eff;
   logic            unused_ok;

   // Request stage: everything the second stage acts on is captured here.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         req   <= 1'b0;
         we    <= 1'b0;
         addr  <= REG_SETUP;
         wdata <= '0;
      end else begin
         req   <= i_wb_stb && i_wb_cyc;
         we    <= i_wb_we;
         addr  <= reg_addr_t'(i_wb_addr);
         wdata <= i_wb_data;
      end
   end

   assign wr_req   = req && we;
   assign rd_req   = req && !we;
   assign setup_wr = wr_req && (addr == REG_SETUP);
   assign rxreg_rd = rd_req && (addr == REG_RXREG);
   assign rx_clr   = setup_wr || (wr_req && (addr == REG_RXREG) && wdata[BIT_RESET]);
   assign tx_clr   = setup_wr || (wr_req && (addr == REG_TXREG) && wdata[BIT_RESET]);
   assign tx_push  = wr_req && (addr == REG_TXREG) && !wdata[BIT_RESET];
   assign tx_pop   = !tx_empty && !i_console_busy;

   sfifo_fwft #(.WIDTH(BW), .LGFLEN(LGFLEN)) u_rxfifo (
      .clk       (i_clk),
      .rst       (i_reset),
      .clr       (rx_clr),
      .push      (i_console_stb),
      .push_data (i_console_data),
      .pop       (rxreg_rd),
      .head      (rx_head),
      .fill      (rx_fill),
      .full      (rx_full),
      .empty     (rx_empty),
      .overflow  (rx_ovf)
   );

   sfifo_fwft #(.WIDTH(BW), .LGFLEN(LGFLEN)) u_txfifo (
      .clk       (i_clk),
      .rst       (i_reset),
      .clr       (tx_clr),
      .push      (tx_push),
      .push_data (wdata[BW-1:0]),
      .pop       (tx_pop),
      .head      (tx_head),
      .fill      (tx_fill),
      .full      (tx_full),
      .empty     (tx_empty),
      .overflow  (tx_ovf)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rx_thresh <= '0;
         timeout   <= '0;
         rx_err    <= 1'b0;
         tx_err    <= 1'b0;
      end else begin
         if (setup_wr) begin
            rx_thresh <= wdata[10:0];
            timeout   <= wdata[16 +: TOW];
         end
         if (rx_clr)
            rx_err <= 1'b0;
         else if (rx_ovf)
            rx_err <= 1'b1;
         if (tx_clr)
            tx_err <= 1'b0;
         else if (tx_ovf)
            tx_err <= 1'b1;
      end
   end

   // Idle timer: the count saturates at the programmed value so the flag stays put.
   assign to_clear = i_console_stb || rxreg_rd || rx_empty || rx_clr;
   assign to_inc   = to_count + TOW'(1);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         to_count <= '0;
         to_flag  <= 1'b0;
      end else begin
         if (to_clear)
            to_count <= '0;
         else if ((timeout != '0) && (to_count != timeout)) begin
            to_count <= to_inc;
            if (to_inc == timeout)
               to_flag <= 1'b1;
         end
         if (rxreg_rd || setup_wr)
            to_flag <= 1'b0;
      end
   end

   assign tx_free = DEPTH - tx_fill;

   always_comb begin
      rd_word = '0;
      case (addr)
         REG_SETUP: begin
            rd_word[10:0]       = rx_thresh;
            rd_word[16 +: TOW]  = timeout;
         end
         REG_FIFO: begin
            rd_word[31:28] = 4'(LGFLEN);
            rd_word[26:16] = 11'(tx_free);
            rd_word[15:12] = 4'(LGFLEN);
            rd_word[10:0]  = 11'(rx_fill);
         end
         REG_RXREG: begin
            if (!rx_empty)
               rd_word[BW-1:0] = rx_head;
            rd_word[BIT_RX_EMPTY] = rx_empty;
            rd_word[BIT_TIMEOUT]  = to_flag;
            rd_word[BIT_ERR]      = rx_err;
         end
         REG_TXREG: begin
            if (!tx_empty)
               rd_word[BW-1:0] = tx_head;
            rd_word[BIT_TX_NEMPTY] = !tx_empty;
            rd_word[BIT_TX_FULL]   = tx_full;
            rd_word[BIT_ERR]       = tx_err;
            rd_word[BIT_TXHALF]    = o_txfifo_int;
         end
         default: rd_word = '0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ack       <= 1'b0;
         o_wb_data <= '0;
      end else begin
         ack <= req && i_wb_cyc;
         if (rd_req)
            o_wb_data <= rd_word;
      end
   end

   // A bus master that drops CYC abandons the cycle, so the ack is qualified live.
   assign o_wb_ack       = ack && i_wb_cyc;
   assign o_wb_stall     = 1'b0;
   assign o_console_stb  = !tx_empty;
   assign o_console_data = tx_head;

   assign thresh_eff     = (rx_thresh == '0) ? 11'd1 : rx_thresh;
   assign o_rx_int       = !rx_empty;
   assign o_rxthresh_int = (11'(rx_fill) >= thresh_eff) || to_flag;
   assign o_tx_int       = !tx_full;
   assign o_txfifo_int   = (tx_fill < HALF);

   assign unused_ok = &{1'b0, wdata, rx_full};

endmodule
`default_nettype wire

// File: tb/tb_wbconsole_gen.sv
`default_nettype none
// tb_wbconsole_gen -- randomized self-checking bench against a queue-based console model.  Rev 1.0
module tb_wbconsole_gen;

   localparam int BW     = 8;
   localparam int LGFLEN = 4;
   localparam int TOW    = 16;
   localparam int DEPTH  = 16;

   localparam logic [1:0] A_SETUP = 2'd0;
   localparam logic [1:0] A_FIFO  = 2'd1;
   localparam logic [1:0] A_RXREG = 2'd2;
   localparam logic [1:0] A_TXREG = 2'd3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_cyc, wb_stb, wb_we;
   logic [1:0]    wb_addr;
   logic [31:0]   wb_wdata;
   logic          wb_ack, wb_stall;
   logic [31:0]   wb_rdata;
   logic          con_tx_stb;
   logic [BW-1:0] con_tx_data;
   logic          con_busy;
   logic          con_rx_stb;
   logic [BW-1:0] con_rx_data;
   logic          rx_int, rxthresh_int, tx_int, txfifo_int;

   always #5 clk = ~clk;

   wbconsole_gen #(.BW(BW), .LGFLEN(LGFLEN), .TOW(TOW)) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_wb_cyc       (wb_cyc),
      .i_wb_stb       (wb_stb),
      .i_wb_we        (wb_we),
      .i_wb_addr      (wb_addr),
      .i_wb_data      (wb_wdata),
      .o_wb_ack       (wb_ack),
      .o_wb_stall     (wb_stall),
      .o_wb_data      (wb_rdata),
      .o_console_stb  (con_tx_stb),
      .o_console_data (con_tx_data),
      .i_console_busy (con_busy),
      .i_console_stb  (con_rx_stb),
      .i_console_data (con_rx_data),
      .o_rx_int       (rx_int),
      .o_rxthresh_int (rxthresh_int),
      .o_tx_int       (tx_int),
      .o_txfifo_int   (txfifo_int)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain queues plus sticky flags.
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   bit         m_overrun, m_txerr, m_toflag;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_clear_all();
      rxq.delete();
      txq.delete();
      m_overrun = 0;
      m_txerr   = 0;
      m_toflag  = 0;
   endtask

   function automatic logic [31:0] exp_fifo();
      logic [31:0] v = '0;
      v[31:28] = 4'(LGFLEN);
      v[26:16] = 11'(DEPTH - txq.size());
      v[15:12] = 4'(LGFLEN);
      v[10:0]  = 11'(rxq.size());
      return v;
   endfunction

   function automatic logic [31:0] exp_txreg();
      logic [31:0] v = '0;
      if (txq.size() != 0) v[7:0] = txq[0];
      v[8]  = (txq.size() != 0);
      v[9]  = (txq.size() == DEPTH);
      v[12] = m_txerr;
      v[13] = (txq.size() < DEPTH/2);
      return v;
   endfunction

   // Expected RXREG read word; applies the read's side effects to the model.
   function automatic logic [31:0] exp_rxreg_pop();
      logic [31:0] v = '0;
      if (rxq.size() == 0) v[8] = 1'b1;
      else v[7:0] = rxq.pop_front();
      v[9]  = m_toflag;
      v[12] = m_overrun;
      m_toflag = 0;
      return v;
   endfunction

   // Entered and left on a negedge; optional RX strobe lands on the second-stage edge.
   task automatic wb_xfer(input bit w, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] q, input bit rx_mid = 0,
                          input logic [7:0] rx_d = 8'h00);
      wb_cyc = 1; wb_stb = 1; wb_we = w; wb_addr = a; wb_wdata = d;
      @(negedge clk);
      wb_stb = 0;
      if (rx_mid) begin con_rx_stb = 1; con_rx_data = rx_d; end
      @(negedge clk);
      con_rx_stb = 0;
      check_value("wb_ack", 32'(wb_ack), 32'd1);
      q = wb_rdata;
      wb_cyc = 0; wb_we = 0;
   endtask

   task automatic rx_push(input logic [7:0] d);
      con_rx_stb = 1; con_rx_data = d;
      if (rxq.size() < DEPTH) rxq.push_back(d);
      else m_overrun = 1;
      @(negedge clk);
      con_rx_stb = 0;
   endtask

   task automatic tx_write(input logic [7:0] d);
      logic [31:0] q;
      wb_xfer(1, A_TXREG, {24'h0, d}, q);
      if (txq.size() < DEPTH) txq.push_back(d);
      else m_txerr = 1;
   endtask

   task automatic tx_drain();
      for (int c = 0; c < 300 && (txq.size() != 0 || con_tx_stb); c++) begin
         con_busy = 1'($urandom_range(0, 1));
         check_value("tx_stb", 32'(con_tx_stb), 32'(txq.size() != 0));
         if (con_tx_stb && !con_busy)
            check_value("tx_data", 32'(con_tx_data),
                        (txq.size() != 0) ? 32'(txq.pop_front()) : 32'hDEAD);
         @(negedge clk);
      end
      con_busy = 0;
      check_value("tx_drained_stb", 32'(con_tx_stb), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q, e;
      int k, n, th;
      logic [7:0] d;

      rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0;
      con_busy = 0; con_rx_stb = 0; con_rx_data = 0;
      model_clear_all();
      repeat (3) @(negedge clk);
      check_value("rst_ack", 32'(wb_ack), 32'd0);
      check_value("rst_tx_stb", 32'(con_tx_stb), 32'd0);
      check_value("rst_ints", {rx_int, rxthresh_int, tx_int, txfifo_int}, 32'b0011);
      rst = 0;
      @(negedge clk);
      wb_xfer(0, A_FIFO, 0, q);
      check_value("rst_fifo_reg", q, 32'h4010_4000);

      // TX held by busy, then released
      con_busy = 1;
      tx_write(8'h41);
      tx_write(8'h42);
      for (int i = 0; i < 5; i++) begin
         check_value("busy_stb", 32'(con_tx_stb), 32'd1);
         check_value("busy_data", 32'(con_tx_data), 32'h41);
         @(negedge clk);
      end
      wb_xfer(0, A_TXREG, 0, q);
      check_value("txreg_two", q, exp_txreg());
      tx_drain();

      // Random TX burst, possibly overflowing
      con_busy = 1;
      n = $urandom_range(12, 20);
      for (int i = 0; i < n; i++) tx_write(8'($urandom));
      wb_xfer(0, A_TXREG, 0, q);
      check_value("txreg_burst", q, exp_txreg());
      check_value("tx_int_burst", 32'(tx_int), 32'(txq.size() < DEPTH));
      wb_xfer(0, A_FIFO, 0, q);
      check_value("fifo_burst", q, exp_fifo());
      tx_drain();
      wb_xfer(0, A_TXREG, 0, q);
      check_value("txreg_drained", q, exp_txreg());
      wb_xfer(1, A_TXREG, 32'h1000, q);
      m_txerr = 0; txq.delete();
      wb_xfer(0, A_TXREG, 0, q);
      check_value("txreg_reset", q, exp_txreg());

      // RX overrun: 17 strobes, 17 reads
      for (int i = 0; i < 17; i++) rx_push(8'($urandom));
      wb_xfer(0, A_FIFO, 0, q);
      check_value("fifo_rx_full", q, exp_fifo());
      check_value("rx_int_full", 32'(rx_int), 32'd1);
      for (int i = 0; i < 17; i++) begin
         e = exp_rxreg_pop();
         wb_xfer(0, A_RXREG, 0, q);
         check_value("rxreg_ovr", q, e);
      end
      wb_xfer(1, A_RXREG, 32'h1000, q);
      m_overrun = 0; rxq.delete();
      e = exp_rxreg_pop();
      wb_xfer(0, A_RXREG, 0, q);
      check_value("rxreg_after_clr", q, e);

      // Random RX count, read back in order
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) rx_push(8'($urandom));
      for (int i = 0; i <= n; i++) begin
         e = exp_rxreg_pop();
         wb_xfer(0, A_RXREG, 0, q);
         check_value("rxreg_rand", q, e);
      end

      // Threshold 4, timeout 10
      wb_xfer(1, A_SETUP, 32'h000A_0004, q);
      model_clear_all();
      wb_xfer(0, A_SETUP, 0, q);
      check_value("setup_rd", q, 32'h000A_0004);
      rx_push(8'($urandom));
      rx_push(8'($urandom));
      k = 0;
      while (!rxthresh_int && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_value("timeout_delay", 32'(k), 32'd10);
      m_toflag = 1;
      e = exp_rxreg_pop();
      wb_xfer(0, A_RXREG, 0, q);
      check_value("rxreg_timeout", q, e);
      check_value("rxthresh_cleared", 32'(rxthresh_int), 32'd0);
      for (int i = 0; i < 3; i++) rx_push(8'($urandom));
      check_value("rxthresh_fill4", 32'(rxthresh_int), 32'd1);

      // Random thresholds (first pass programs 0, which acts as 1)
      for (int pass = 0; pass < 4; pass++) begin
         th = (pass == 0) ? 0 : $urandom_range(1, 16);
         n  = $urandom_range(0, 16);
         wb_xfer(1, A_SETUP, 32'(th), q);
         model_clear_all();
         for (int i = 0; i < n; i++) rx_push(8'($urandom));
         check_value("rxthresh_rand", 32'(rxthresh_int), 32'(n >= ((th == 0) ? 1 : th)));
         wb_xfer(0, A_FIFO, 0, q);
         check_value("fifo_rand", q, exp_fifo());
      end

      // Full RX FIFO: strobe coincides with a pop
      wb_xfer(1, A_SETUP, 0, q);
      model_clear_all();
      for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom));
      d = 8'($urandom);
      e = exp_rxreg_pop();
      rxq.push_back(d);
      wb_xfer(0, A_RXREG, 0, q, 1, d);
      check_value("rxreg_full_simul", q, e);
      wb_xfer(0, A_FIFO, 0, q);
      check_value("fifo_full_simul", q, exp_fifo());
      e = exp_rxreg_pop();
      wb_xfer(0, A_RXREG, 0, q);
      check_value("rxreg_no_overrun", q, e);

      // Asynchronous reset while TX is pending and an ack is on the bus
      con_busy = 1;
      for (int i = 0; i < 3; i++) tx_write(8'($urandom));
      wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = A_TXREG;
      @(negedge clk);
      wb_stb = 0;
      @(negedge clk);
      check_value("pre_rst_ack", 32'(wb_ack), 32'd1);
      #2 rst = 1;
      #1;
      check_value("async_rst_stb", 32'(con_tx_stb), 32'd0);
      check_value("async_rst_ack", 32'(wb_ack), 32'd0);
      check_value("async_rst_ints", {rx_int, tx_int, txfifo_int}, 32'b011);
      model_clear_all();
      wb_cyc = 0;
      @(negedge clk);
      rst = 0;
      con_busy = 0;
      @(negedge clk);
      wb_xfer(0, A_FIFO, 0, q);
      check_value("post_rst_fifo", q, exp_fifo());

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
